// File: rtl/mix_columns_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) constant-multiply helpers
// used by the sequential (Inv)MixColumns engine.
package mix_columns_pkg;

  localparam int          AES_STATE_W = 128;
  localparam int          AES_COL_W   = 32;
  localparam logic [7:0]  AES_POLY    = 8'h1B;
  localparam logic        MC_FWD      = 1'b0;
  localparam logic        MC_INV      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // The inverse coefficients are sums of x, x^2 and x^3 multiples of b.
  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_columns_seq_gf_col_mix.sv
// Combinational (Inv)MixColumns of one 32-bit column, row 0 in the MSB byte.
// With INV_EN=0 only the forward matrix is built and inv is ignored.
module gf_col_mix
  import mix_columns_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [AES_COL_W-1:0] col,
  input  logic                 inv,
  output logic [AES_COL_W-1:0] res
);

  logic [7:0]           a [4];
  logic [AES_COL_W-1:0] fwd_col;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i] = col[AES_COL_W-1-8*i -: 8];
    end
  end

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fwd_col = '0;
    for (int i = 0; i < 4; i++) begin
      fwd_col[AES_COL_W-1-8*i -: 8] = mul2(a[i]) ^ mul3(a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
  end

  if (INV_EN) begin : g_inv
    logic [AES_COL_W-1:0] inv_col;

    always_comb begin
      inv_col = '0;
      for (int i = 0; i < 4; i++) begin
        inv_col[AES_COL_W-1-8*i -: 8] = mule(a[i]) ^ mulb(a[(i+1)%4]) ^
                                         muld(a[(i+2)%4]) ^ mul9(a[(i+3)%4]);
      end
    end

    assign res = inv ? inv_col : fwd_col;
  end else begin : g_fwd_only
    assign res = fwd_col;
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Handshaked AES (Inv)MixColumns engine: a 128-bit state is latched, transformed
// COLS_PER_CYCLE columns per clock in place, then held until the consumer takes it.
module mix_columns_seq
  import mix_columns_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit SUPPORT_INV    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         NCYC = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NCYC - 1);

  mc_state_t              state, state_next;
  logic [1:0]             cnt;
  logic [AES_STATE_W-1:0] work, work_next;
  logic                   mode;
  logic                   started;
  logic                   accept;

  logic [1:0]             col_idx [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0]   col_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0]   col_out [COLS_PER_CYCLE];

  // started keeps in_ready low while reset is held and for the release cycle itself.
  assign in_ready  = started & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);
  assign out_state = work;

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx[k] = 2'(int'(cnt) * COLS_PER_CYCLE + k);
      col_in[k]  = work[AES_STATE_W-1-AES_COL_W*int'(col_idx[k]) -: AES_COL_W];
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    gf_col_mix #(
      .INV_EN (SUPPORT_INV)
    ) u_col (
      .col (col_in[k]),
      .inv (mode),
      .res (col_out[k])
    );
  end

  always_comb begin
    work_next = work;
    if (accept) begin
      work_next = in_state;
    end else if (state == ST_BUSY) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        work_next[AES_STATE_W-1-AES_COL_W*int'(col_idx[k]) -: AES_COL_W] = col_out[k];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (cnt == LAST) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = accept ? ST_BUSY : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the wide work register is
  // a plain datapath flop (not a memory array), so it is reset to give out_state=0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      work    <= '0;
      mode    <= MC_FWD;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_next;
      work    <= work_next;
      if (accept) begin
        cnt  <= 2'd0;
        mode <= SUPPORT_INV ? in_inv : MC_FWD;
      end else if (state == ST_BUSY) begin
        cnt  <= (cnt == LAST) ? 2'd0 : cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: four instances (1/2/4 columns per clock, plus a
// forward-only build) each get directed vectors; a per-instance monitor checks results.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    logic [7:0]   k [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gm(k[j], a[(i+j)%4]);
        r[127-32*c-8*i -: 8] = b;
      end
    end
    return r;
  endfunction

  logic [31:0]  v_in  [5] = '{32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6};
  logic [31:0]  v_out [5] = '{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6};
  logic [127:0] st_a = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  logic [127:0] st_b = 128'h046681e5e0cb199a48f8d37a2806264c;
  logic [127:0] st_1 = {4{32'h01010101}};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int C  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam bit SI = (g != 3);
    localparam int N  = 4 / C;

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;
    logic [127:0] exp_q [$];
    int           acc_cyc = 0;
    bit           fin = 1'b0;
    string        tag = $sformatf("C%0d_S%0d", C, SI);

    mix_columns_seq #(
      .COLS_PER_CYCLE (C),
      .SUPPORT_INV    (SI)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
    );

    always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s unexpected_output actual=%h expected=none", tag, out_state);
        end else begin
          check({tag, " result"}, out_state, exp_q.pop_front());
        end
      end
    end

    // Presents a state just after a rising edge and returns #1 after the accepting edge.
    task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] e);
      bit ok = 1'b0;
      @(posedge clk); #1;
      in_state = s;
      in_inv   = inv;
      in_valid = 1'b1;
      exp_q.push_back(e);
      for (int i = 0; i < 64 && !ok; i++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL %s accept_timeout actual=no_in_ready expected=in_ready", tag);
      end
      @(posedge clk);
      acc_cyc = cyc;
      #1 in_valid = 1'b0;
    endtask

    // out_valid must be low at the falling edges after T..T+N-1 and high after T+N.
    task automatic latency_check(input string name);
      for (int i = 0; i <= N; i++) begin
        @(negedge clk);
        check({tag, " ", name}, {127'd0, out_valid}, {127'd0, (i == N)});
      end
    endtask

    task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
        @(negedge clk);
        if (exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL %s drain_timeout actual=%0d_pending expected=0", tag, exp_q.size());
      end
    endtask

    initial begin
      #12;
      check({tag, " rst_in_ready"},  {127'd0, in_ready},  128'd0);
      check({tag, " rst_out_valid"}, {127'd0, out_valid}, 128'd0);
      check({tag, " rst_busy"},      {127'd0, busy},      128'd0);
      check({tag, " rst_out_state"}, out_state,           128'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check({tag, " post_rst_in_ready"}, {127'd0, in_ready}, 128'd1);

      // Single columns with latency check.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        send({v_in[i], 96'h0}, 1'b0, {v_out[i], 96'h0});
        latency_check($sformatf("latency_v%0d", i));
      end
      send({32'h8e4da1bc, 96'h0}, 1'b1,
           SI ? {32'hdb135345, 96'h0} : mix_ref({32'h8e4da1bc, 96'h0}, 1'b0));
      drain();

      // Full state forward, then inverse round trip (forward-only build ignores in_inv).
      send(st_a, 1'b0, st_b);
      send(st_b, 1'b1, SI ? st_a : mix_ref(st_b, 1'b0));
      if (!SI) send(st_a, 1'b1, st_b);
      drain();

      // Backpressure: result held with in_inv/in_state churning underneath.
      out_ready = 1'b0;
      send(st_a, 1'b0, st_b);
      for (int j = 1; j <= N + 10; j++) begin
        @(posedge clk); #1;
        in_inv   = ~in_inv;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        if (j >= N) begin
          check({tag, " bp_out_valid"}, {127'd0, out_valid}, 128'd1);
          check({tag, " bp_out_state"}, out_state, st_b);
          check({tag, " bp_in_ready"},  {127'd0, in_ready},  128'd0);
        end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      drain();

      // Back-to-back: second state accepted on the edge the first result retires.
      begin
        int a_cyc;
        send({v_in[1], 96'h0}, 1'b0, {v_out[1], 96'h0});
        a_cyc = acc_cyc;
        send(st_a, 1'b0, st_b);
        check({tag, " b2b_accept_gap"}, 128'(acc_cyc - a_cyc), 128'(N + 1));
        latency_check("b2b_latency");
        drain();
      end

      // Reset in the middle of a transaction.
      send(st_a, 1'b0, st_b);
      if (N > 1) begin
        @(posedge clk); #1;
      end
      check({tag, " pre_rst_busy"}, {127'd0, busy}, 128'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check({tag, " midrst_out_valid"}, {127'd0, out_valid}, 128'd0);
      check({tag, " midrst_busy"},      {127'd0, busy},      128'd0);
      check({tag, " midrst_out_state"}, out_state,           128'd0);
      check({tag, " midrst_in_ready"},  {127'd0, in_ready},  128'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check({tag, " rel_in_ready"}, {127'd0, in_ready}, 128'd1);
      send(st_1, 1'b0, st_1);
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    bit all_done = 1'b0;
    for (int i = 0; i < 20000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_dut[0].fin && g_dut[1].fin && g_dut[2].fin && g_dut[3].fin;
    end
    if (!all_done) begin
      checks++;
      failures++;
      $display("FAIL global_timeout actual=unfinished expected=all_instances_done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
